mem_pipe: RTL



---
 rtl/mem_pipe_pkg.sv | 90 +++++++++
 rtl/mem_pipe_load_align.sv | 25 ++
 rtl/mem_pipe.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_pipe_pkg.sv
// Shared types and helpers for the data-memory pipeline.
// Access-size encodings, store strobes and lane replication.
package mem_pipe_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  tag_t;

  typedef struct packed {
    logic write_rd;
    logic do_load;
    logic do_store;
    logic do_branch;
  } instr_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    LT_IDLE,
    LT_WAIT
  } lt_state_e;

  typedef struct packed {
    logic       valid;
    instr_t     itype;
    logic [2:0] funct3;
    tag_t       rd;
    word_t      value;
    word_t      sdata;
  } s4a_t;

  typedef struct packed {
    logic       valid;
    instr_t     itype;
    logic [2:0] funct3;
    tag_t       rd;
    word_t      value;
  } s4b_t;

  typedef struct packed {
    logic   valid;
    instr_t itype;
    tag_t   rd;
    word_t  value;
  } s5_t;

  function automatic logic [3:0] wstrb_for(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] s;
    unique case (size)
      F3_B:    s = 4'b0001 << a;
      F3_H:    s = a[1] ? 4'b1100 : 4'b0011;
      F3_W:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic word_t lane_rep(
    input logic [2:0] size,
    input word_t      d
  );
    word_t r;
    unique case (size)
      F3_B:    r = {4{d[7:0]}};
      F3_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic m;
    unique case (size)
      F3_H, F3_HU: m = a[0];
      F3_W:        m = |a;
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_pipe_load_align.sv
// Load data alignment: picks the addressed byte/half
// out of the returned word and sign- or zero-extends it.
module load_align
  import mem_pipe_pkg::*;
(
  input  word_t      rdata,
  input  logic [1:0] a,
  input  logic [2:0] funct3,
  output word_t      data
);

  word_t sh;

  always_comb begin
    sh = rdata >> {a, 3'b000};
    unique case (funct3)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   data = {24'h0, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   data = {16'h0, sh[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_pipe.sv
// Stages 4a (issue), 4b (data return) and 5 (result)
// with a single-outstanding load tracker and stall logic.
module mem_pipe
  import mem_pipe_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       s3_valid,
  input  instr_t     s3_instr_type,
  input  logic [2:0] s3_funct3,
  input  tag_t       s3_rd,
  input  word_t      s3_result,
  input  word_t      s3_store_data,
  output logic       dmem_req,
  output logic       dmem_we,
  output word_t      dmem_addr,
  output word_t      dmem_wdata,
  output logic [3:0] dmem_wstrb,
  input  logic       dmem_ready,
  input  logic       dmem_rvalid,
  input  word_t      dmem_rdata,
  output logic       s4a_valid,
  output logic       s4b_valid,
  output logic       s5_valid,
  output instr_t     s4a_instr_type,
  output instr_t     s4b_instr_type,
  output instr_t     s5_instr_type,
  output tag_t       s4a_rd,
  output tag_t       s4b_rd,
  output tag_t       s5_rd,
  output word_t      s4a_value,
  output word_t      s4b_value,
  output word_t      s5_value,
  output logic       mem_stall,
  output logic       misaligned,
  output word_t      misaligned_addr
);

  s4a_t      a_q;
  s4b_t      b_q;
  s5_t       c_q;
  lt_state_e state;
  lt_state_e state_nx;

  logic  waiting;
  logic  a_mem;
  logic  a_mis;
  logic  a_go;
  logic  stall_4a;
  logic  stall_4b;
  logic  stall;
  logic  req;
  logic  ld_acc;
  word_t b_ld;

  always_comb begin
    a_mem = a_q.valid
          && (a_q.itype.do_load || a_q.itype.do_store);
    a_mis = a_mem
          && is_misaligned(a_q.funct3, a_q.value[1:0]);
    a_go  = a_mem && !a_mis;
    stall_4b = b_q.valid && b_q.itype.do_load
             && waiting && !dmem_rvalid;
    stall_4a = a_go && (!dmem_ready || stall_4b);
    stall    = stall_4a || stall_4b;
    req      = a_go && !stall_4b;
    ld_acc   = req && dmem_ready && !a_q.itype.do_store;
  end

  load_align u_align (
    .rdata  (dmem_rdata),
    .a      (b_q.value[1:0]),
    .funct3 (b_q.funct3),
    .data   (b_ld)
  );

  assign s4b_value = b_q.itype.do_load ? b_ld : b_q.value;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      if (!stall) begin
        a_q <= '{valid:  s3_valid,
                 itype:  s3_instr_type,
                 funct3: s3_funct3,
                 rd:     s3_rd,
                 value:  s3_result,
                 sdata:  s3_store_data};
      end
      // a stalled or dropped 4a op leaves a bubble behind it
      if (!stall_4b) begin
        b_q.valid  <= a_q.valid && !a_mis && !stall_4a;
        b_q.itype  <= a_q.itype;
        b_q.funct3 <= a_q.funct3;
        b_q.rd     <= a_q.rd;
        b_q.value  <= a_q.value;
      end
      if (stall_4b) begin
        c_q.valid <= 1'b0;
      end else begin
        c_q <= '{valid: b_q.valid,
                 itype: b_q.itype,
                 rd:    b_q.rd,
                 value: s4b_value};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= LT_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LT_IDLE: if (ld_acc) state_nx = LT_WAIT;
      LT_WAIT: if (dmem_rvalid)
                 state_nx = ld_acc ? LT_WAIT : LT_IDLE;
    endcase
  end

  always_comb begin
    waiting = (state == LT_WAIT);
  end

  assign dmem_req   = req && !reset;
  assign dmem_we    = a_q.itype.do_store;
  assign dmem_addr  = {a_q.value[31:2], 2'b00};
  assign dmem_wdata = lane_rep(a_q.funct3, a_q.sdata);
  assign dmem_wstrb = a_q.itype.do_store
                    ? wstrb_for(a_q.funct3, a_q.value[1:0])
                    : 4'b0000;

  assign mem_stall       = stall && !reset;
  assign misaligned      = a_mis && !stall_4b && !reset;
  assign misaligned_addr = a_q.value;

  assign s4a_valid      = a_q.valid;
  assign s4a_instr_type = a_q.itype;
  assign s4a_rd         = a_q.rd;
  assign s4a_value      = a_q.value;
  assign s4b_valid      = b_q.valid;
  assign s4b_instr_type = b_q.itype;
  assign s4b_rd         = b_q.rd;
  assign s5_valid       = c_q.valid;
  assign s5_instr_type  = c_q.itype;
  assign s5_rd          = c_q.rd;
  assign s5_value       = c_q.value;

endmodule
